// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if : request/response and data-memory bundle of the LSU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DM_ADDRESS-1:0] req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic                  mem_rd;
  logic [3:0]            mem_wr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  // The pipeline plus data memory around the unit.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : data-memory initiator with lane alignment and split access
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     word0_q, word0_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [3:0]            mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic                  idle;
  logic                  cur_write;
  logic [2:0]            cur_funct3;
  logic [DM_ADDRESS-1:0] cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic [1:0]            off;
  logic [3:0]            base_mask;
  logic [7:0]            mask8;
  logic                  split;
  logic                  legal;
  logic [DM_ADDRESS-3:0] word_idx;
  logic [DM_ADDRESS-3:0] word_next;
  logic [2*DATA_W-1:0]   load_pair;
  logic [DATA_W-1:0]     load_word;
  logic [DATA_W-1:0]     ext;

  // In IDLE the access is decoded from the incoming request so the first
  // access cycle can be registered at handshake; afterwards from the latch.
  always_comb begin
    idle       = (state_q == IDLE);
    cur_write  = idle ? bus.req_write  : write_q;
    cur_funct3 = idle ? bus.req_funct3 : funct3_q;
    cur_addr   = idle ? bus.req_addr   : addr_q;
    cur_wdata  = idle ? bus.req_wdata  : wdata_q;
    off        = cur_addr[1:0];
    case (cur_funct3[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      2'b10:   base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
    mask8     = {4'b0000, base_mask} << off;
    split     = |mask8[7:4];
    word_idx  = cur_addr[DM_ADDRESS-1:2];
    word_next = word_idx + {{(DM_ADDRESS-3){1'b0}}, 1'b1};
    if (cur_write) begin
      legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
    end else begin
      legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010) ||
              (cur_funct3 == 3'b100) || (cur_funct3 == 3'b101);
    end
  end

  // Load extraction is only consumed in WAIT, where mem_rdata holds the last word.
  always_comb begin
    load_pair = split ? {bus.mem_rdata, word0_q} : {{DATA_W{1'b0}}, bus.mem_rdata};
    load_word = DATA_W'(load_pair >> {off, 3'b000});
    case (cur_funct3[1:0])
      2'b00:   ext = {{24{~cur_funct3[2] & load_word[7]}}, load_word[7:0]};
      2'b01:   ext = {{16{~cur_funct3[2] & load_word[15]}}, load_word[15:0]};
      default: ext = load_word;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word0_d     = word0_q;
    mem_addr_d  = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 4'b0000;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          state_d  = legal ? ACC0 : RESP;
        end
      end
      ACC0: state_d = split ? ACC1 : (write_q ? RESP : WAIT);
      ACC1: begin
        word0_d = bus.mem_rdata;
        state_d = write_q ? RESP : WAIT;
      end
      WAIT: begin
        if (!split) begin
          word0_d = bus.mem_rdata;
        end
        rsp_rdata_d = ext;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      ACC0: begin
        mem_addr_d = {word_idx, 2'b00};
        if (cur_write) begin
          mem_wr_d    = mask8[3:0];
          mem_wdata_d = cur_wdata << {off, 3'b000};
        end else begin
          mem_rd_d = 1'b1;
        end
      end
      ACC1: begin
        mem_addr_d = {word_next, 2'b00};
        if (cur_write) begin
          mem_wr_d    = mask8[7:4];
          mem_wdata_d = cur_wdata >> (6'd32 - {1'b0, off, 3'b000});
        end else begin
          mem_rd_d = 1'b1;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~legal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      word0_q     <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      word0_q     <= word0_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed vector bench with a behavioural data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  load_store_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:127];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_wr[i]) mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [8:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [8:0]  a0;
    logic [3:0]  wr0;
    logic        rd0;
    logic [31:0] wd0;
    logic [8:0]  a1;
    logic [3:0]  wr1;
    logic        rd1;
    logic [31:0] wd1;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          t;
    int          lat;
    logic [8:0]  a0, a1;
    logic [3:0]  w0, w1;
    logic        r0, r1, er, rdy1;
    logic [31:0] d0, d1, rd;
    string       p;
    p = $sformatf("v%0d", idx);
    a0 = '0; a1 = '0; w0 = '0; w1 = '0; r0 = 0; r1 = 0; er = 0; rdy1 = 1;
    d0 = '0; d1 = '0; rd = '0; lat = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    t = 0;
    while (!bus.req_ready && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) begin
        a0 = bus.mem_addr; w0 = bus.mem_wr; r0 = bus.mem_rd; d0 = bus.mem_wdata;
        rdy1 = bus.req_ready;
      end
      if (k == 2) begin
        a1 = bus.mem_addr; w1 = bus.mem_wr; r1 = bus.mem_rd; d1 = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        lat = k; er = bus.rsp_err; rd = bus.rsp_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({p, " latency"}, lat, v.lat);
    chk({p, " rsp_err"}, {31'b0, er}, {31'b0, v.err});
    chk({p, " rsp_rdata"}, rd, v.rdata);
    chk({p, " busy"}, {31'b0, rdy1}, 32'd0);
    chk({p, " wr0"}, {28'b0, w0}, {28'b0, v.wr0});
    chk({p, " rd0"}, {31'b0, r0}, {31'b0, v.rd0});
    chk({p, " wdata0"}, d0, v.wd0);
    if (v.wr0 != 4'b0 || v.rd0) chk({p, " addr0"}, {23'b0, a0}, {23'b0, v.a0});
    if (v.lat >= 2) begin
      chk({p, " wr1"}, {28'b0, w1}, {28'b0, v.wr1});
      chk({p, " rd1"}, {31'b0, r1}, {31'b0, v.rd1});
      chk({p, " wdata1"}, d1, v.wd1);
      if (v.wr1 != 4'b0 || v.rd1) chk({p, " addr1"}, {23'b0, a1}, {23'b0, v.a1});
    end
    @(posedge clk);
    #1;
    chk({p, " pulse_end"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({p, " ready_back"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic any_rsp;
    vec_t post;
    n_checks = 0;
    n_fail   = 0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_rdata  = '0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[127] = 32'h80123456;
    mem[0]   = 32'h9ABCDE7F;
    mem[12]  = 32'h00008001;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("reset rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset mem_addr", {23'b0, bus.mem_addr}, 32'd0);
    chk("reset mem_rd", {31'b0, bus.mem_rd}, 32'd0);
    chk("reset mem_wr", {28'b0, bus.mem_wr}, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          wr    f3      addr    wdata         lat err  rdata         a0      wr0  rd0  wd0           a1      wr1  rd1  wd1
    vecs[0]  = '{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 2, 1'b0, 32'h00000000, 9'h010, 4'hF, 1'b0, 32'hDEADBEEF, 9'h000, 4'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 9'h013, 32'h000000A5, 2, 1'b0, 32'h00000000, 9'h010, 4'h8, 1'b0, 32'hA5000000, 9'h000, 4'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b000, 9'h013, 32'h0,        3, 1'b0, 32'hFFFFFFA5, 9'h010, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 9'h013, 32'h0,        3, 1'b0, 32'h000000A5, 9'h010, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 3'b010, 9'h022, 32'h11223344, 3, 1'b0, 32'h00000000, 9'h020, 4'hC, 1'b0, 32'h33440000, 9'h024, 4'h3, 1'b0, 32'h00001122};
    vecs[5]  = '{1'b0, 3'b010, 9'h022, 32'h0,        4, 1'b0, 32'h11223344, 9'h020, 4'h0, 1'b1, 32'h0,        9'h024, 4'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 3'b001, 9'h1FF, 32'h0,        4, 1'b0, 32'h00007F80, 9'h1FC, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'b101, 9'h030, 32'h0,        3, 1'b0, 32'h00008001, 9'h030, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 3'b001, 9'h030, 32'h0,        3, 1'b0, 32'hFFFF8001, 9'h030, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 9'h040, 32'h0,        1, 1'b1, 32'h00000000, 9'h000, 4'h0, 1'b0, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 9'h040, 32'h12345678, 1, 1'b1, 32'h00000000, 9'h000, 4'h0, 1'b0, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 9'h041, 32'hFFFFBEEF, 2, 1'b0, 32'h00000000, 9'h040, 4'h6, 1'b0, 32'hFFBEEF00, 9'h000, 4'h0, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 9'h040, 32'h0,        3, 1'b0, 32'h00BEEF00, 9'h040, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 3'b000, 9'h042, 32'h0,        3, 1'b0, 32'hFFFFFFBE, 9'h040, 4'h0, 1'b1, 32'h0,        9'h000, 4'h0, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 3'b001, 9'h023, 32'h0000CAFE, 3, 1'b0, 32'h00000000, 9'h020, 4'h8, 1'b0, 32'hFE000000, 9'h024, 4'h1, 1'b0, 32'h000000CA};
    vecs[15] = '{1'b0, 3'b101, 9'h023, 32'h0,        4, 1'b0, 32'h0000CAFE, 9'h020, 4'h0, 1'b1, 32'h0,        9'h024, 4'h0, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 3'b010, 9'h021, 32'h0,        4, 1'b0, 32'hCAFE4400, 9'h020, 4'h0, 1'b1, 32'h0,        9'h024, 4'h0, 1'b1, 32'h0};

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Reset asserted in the middle of ACC1 of a split store abandons the second word.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 9'h022;
    bus.req_wdata  = 32'h55667788;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst acc1 wr", {28'b0, bus.mem_wr}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("rst mem_wr", {28'b0, bus.mem_wr}, 32'd0);
    chk("rst mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst mem_addr", {23'b0, bus.mem_addr}, 32'd0);
    chk("rst req_ready", {31'b0, bus.req_ready}, 32'd1);
    any_rsp = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) any_rsp = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) any_rsp = 1'b1;
    end
    chk("rst no rsp", {31'b0, any_rsp}, 32'd0);

    post = '{1'b0, 3'b010, 9'h022, 32'h0, 4, 1'b0, 32'h11CA7788, 9'h020, 4'h0, 1'b1, 32'h0, 9'h024, 4'h0, 1'b1, 32'h0};
    run_vec(post, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage and drives the data memory's word address, byte write enables and read strobe. Byte/half/word store data is aligned into lanes, and load data is extracted and sign- or zero-extended. Accesses that cross a word boundary are split into two word accesses. Returns a single-cycle response pulse to the pipeline, which stalls on `req_ready`.

## Interface
- `DM_ADDRESS`, 9: data-memory byte-address width.
- `DATA_W`, 32: data width; fixed at 32 for this block.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; handshake completes when `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  instruction bits 14:12 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  DM_ADDRESS  byte address from the ALU.
- `req_wdata`  in  DATA_W  store data, right-justified.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_err`  out  1  illegal funct3; qualified by `rsp_valid`.
- `rsp_rdata`  out  DATA_W  extended load data; 0 for stores and errors.
- `mem_addr`  out  DM_ADDRESS  word-aligned byte address; bits [1:0] always 0.
- `mem_rd`  out  1  read strobe.
- `mem_wr`  out  4  byte write enables; bit i writes lane [8i+7:8i].
- `mem_wdata`  out  DATA_W  lane-aligned store data.
- `mem_rdata`  in  DATA_W  word read data, valid in the cycle after the `mem_rd` cycle.

## Operation
- FSM states: IDLE, ACC0, ACC1, WAIT, RESP.
- `req_ready` = (state == IDLE).
- On handshake, the unit latches `req_write`, `req_funct3`, `req_addr` and `req_wdata`.
- off = `addr[1:0]`; size = 1/2/4 bytes for funct3[1:0] = 00/01/10.
- mask8 = ({0001, 0011, 1111}[size]) << off, 8 bits wide.
- Split access iff mask8[7:4] != 0.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Illegal funct3: IDLE -> RESP directly, with no memory strobes, `rsp_err=1` and `rsp_rdata=0`.
- ACC0: `mem_addr` = {addr[DM_ADDRESS-1:2], 00}.
  - Store: `mem_wr` = mask8[3:0], `mem_wdata` = wdata << 8·off.
  - Load: `mem_rd` = 1, `mem_wr` = 0.
- ACC1 (split only): `mem_addr` = ACC0 address + 4, wrapping modulo 2^DM_ADDRESS (top word wraps to 0).
  - Store: `mem_wr` = mask8[7:4], `mem_wdata` = wdata >> 8·(4−off).
  - Load: `mem_rd` = 1.
- Transitions:
  - ACC0 -> ACC1 if split, else load -> WAIT, store -> RESP.
  - ACC1 -> WAIT for a load, RESP for a store.
  - WAIT -> RESP.
- Load data capture:
  - word0 is registered from `mem_rdata` at the end of the cycle after ACC0 (ACC1 or WAIT).
  - word1 is registered at the end of WAIT when split.
- Extraction: {word1, word0} >> 8·off; take the low `size` bytes.
  - funct3[2] = 0: sign-extend. funct3[2] = 1: zero-extend.
  - `rsp_rdata` is registered before RESP.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE.
- All `mem_*` strobes are 0 in IDLE, WAIT and RESP. `mem_wdata` is 0 whenever `mem_wr` = 0.
- Reset (asynchronous, any state):
  - state IDLE, `req_ready=1`.
  - `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata` all 0.
  - An in-flight access is abandoned and no response is produced; strobes drop immediately.

## Timing
- Handshake in cycle T.
- Aligned store: ACC0 at T+1, `rsp_valid` at T+2.
- Split store: ACC0 at T+1, ACC1 at T+2, `rsp_valid` at T+3.
- Aligned load: ACC0 at T+1, WAIT at T+2, `rsp_valid` at T+3.
- Split load: ACC0 at T+1, ACC1 at T+2, WAIT at T+3, `rsp_valid` at T+4.
- Illegal funct3: `rsp_valid` at T+1.
- The next handshake happens no earlier than the cycle after RESP. `req_*` is ignored outside IDLE.
- Memory outputs are registered (state-decoded from latched fields) and never depend combinationally on `req_*`.

## Test plan
- SW addr 0x010 wdata 0xDEADBEEF -> one ACC0 cycle with `mem_addr`=0x010, `mem_wr`=1111, `mem_wdata`=0xDEADBEEF; `rsp_valid` 2 cycles after handshake.
- SB addr 0x013 wdata 0x000000A5 -> `mem_wr`=1000, `mem_wdata`=0xA5000000. Then LB at 0x013 -> `rsp_rdata`=0xFFFFFFA5; LBU at 0x013 -> 0x000000A5.
- SW addr 0x022 wdata 0x11223344 -> ACC0 at 0x020 with `mem_wr`=1100, data 0x33440000; ACC1 at 0x024 with `mem_wr`=0011, data 0x00001122. LW at 0x022 -> 0x11223344 at T+4.
- LH at 0x1FF with word 0x1FC = 0x80xxxxxx and word 0x000 = 0xxxxxxx7F -> split with ACC1 `mem_addr`=0x000 (wrap); `rsp_rdata`=0x00007F80.
- LHU with mem bytes giving 0x8001 -> 0x00008001. funct3=011 load -> no strobes, `rsp_valid` at T+1 with `rsp_err`=1 and `rsp_rdata`=0.
- `rst_n` pulsed low during ACC1 of a split store -> `mem_wr` drops to 0 at once, no `rsp_valid`, `req_ready`=1; the next request completes normally.
